mem_march_bist: RTL and testbench
=================================

# mem_march_bist

Memory self-test initiator that drives one port of the shared 32-bit single-cycle RAM request/response interface: it writes a seeded pattern over a word range, reads the range back, and compares every response. It sits beside the dual-port RAM, for example on port B while the core owns port A. It is used for power-on RAM checks and as a protocol-level traffic source in simulation.

## Interface
Parameters:
- Depth, 128: number of 32-bit words tested; must be ≥ 2.
- BaseAddr, 32'h0: byte address of the first word; must be word-aligned.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- start_i  in  1  start a test run; sampled only in IDLE.
- pattern_i  in  32  seed; sampled and held at start.
- busy_o  out  1  run in progress.
- done_o  out  1  one-cycle pulse at the end of a run.
- error_o  out  1  sticky fail flag; cleared by the next accepted start.
- err_addr_o  out  32  byte address of the first failure.
- err_rdata_o  out  32  read data at the first failure.
- mem_req_o  out  1  request.
- mem_we_o  out  1  1 = write, 0 = read.
- mem_be_o  out  4  byte enables; always 4'hF when mem_req_o = 1, else 0.
- mem_addr_o  out  32  byte address.
- mem_wdata_o  out  32  write data.
- mem_rvalid_i  in  1  response valid; the RAM asserts it one cycle after every request, reads and writes alike.
- mem_rdata_i  in  32  read data, qualified by mem_rvalid_i.

## Operation
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - start_i = 1 latches pattern_i into the seed, clears error_o, err_addr_o and err_rdata_o, zeroes index i, and moves to WRITE.
- WRITE:
  - Each cycle issues req=1, we=1, addr = BaseAddr + 4*i, wdata = seed ^ i (i zero-extended to 32 bits).
  - i increments each cycle. After the write with i = Depth-1, i resets to 0 and the FSM moves to READ.
- READ:
  - Each cycle issues req=1, we=0, addr = BaseAddr + 4*i.
  - A pending register records expected = seed ^ i, the address, and pend = 1.
  - After the read with i = Depth-1, the FSM moves to DRAIN.
- DRAIN: no request; waits for the last response, then moves to DONE.
- DONE: done_o = 1 for one cycle; the FSM returns to IDLE.
- Compare rule, applied in the cycle after each read issue (pend = 1):
  - Mismatch: mem_rvalid_i = 1 and mem_rdata_i ≠ expected.
  - Missing response: mem_rvalid_i = 0. err_rdata_o captures 32'h0.
  - Either case sets error_o.
  - err_addr_o and err_rdata_o are captured only if error_o was 0 (first failure wins).
- Responses arriving when pend = 0 are ignored. This covers the write acknowledges and any stray rvalid.
- A run always completes all Depth reads even after a failure.
- start_i while busy_o = 1 or in DONE is ignored.
- Index counter width is $clog2(Depth)+1; no wrap occurs within a run.
- Reset mid-run: all state returns to reset values immediately, including error and capture registers, and no further requests are issued. A new start_i after reset runs normally.

## Timing
- Reset values: busy_o, done_o, error_o, mem_req_o, mem_we_o = 0; mem_be_o = 0; err_addr_o, err_rdata_o, mem_addr_o, mem_wdata_o = 0.
- All mem_* outputs and status outputs are registered.
- Let cycle 0 be the clock edge that samples start_i:
  - Writes are issued in cycles 1..Depth.
  - Reads are issued in cycles Depth+1..2*Depth.
  - DRAIN occurs in cycle 2*Depth+1.
  - done_o pulses in cycle 2*Depth+2.
- busy_o = 1 exactly in cycles 1..2*Depth+1. Throughput is one request per cycle with no bubbles between WRITE and READ.
- The response to a read issued in cycle n is compared in cycle n+1. error_o is visible from cycle n+2.
- error_o, err_addr_o and err_rdata_o hold after done_o until the next accepted start_i.

## Test plan
- Depth=4, BaseAddr=0x100, pattern 0xA5A50000, ideal RAM model:
  - Writes 0x100..0x10C carry data 0xA5A50000..0xA5A50003.
  - Reads follow in cycles 5..8.
  - done_o pulses in cycle 10; error_o = 0.
- Same setup, with the model flipping bit 0 of the read data at 0x108:
  - error_o = 1, err_addr_o = 0x108, err_rdata_o = 0xA5A50003.
  - done_o still pulses in cycle 10.
- Corrupt the reads at both 0x104 and 0x10C: err_addr_o = 0x104 (first failure retained).
- Suppress rvalid for the read at 0x100: error_o = 1, err_addr_o = 0x100, err_rdata_o = 0.
- Pulse start_i in cycle 3 of a run: ignored; timing is unchanged and exactly 8 requests are issued.
- Assert rst_ni low during WRITE (cycle 2):
  - All outputs read 0 while reset is asserted.
  - A subsequent start with pattern 0 completes with error_o = 0, and the next run clears a previously set error_o.

Source files
------------

// File: rtl/mem_march_bist.sv
// Purpose: RAM self-test initiator; writes seed^index over Depth words, reads them back, flags the first mismatch.
// Latency: start sampled at cycle 0, writes in 1..Depth, reads in Depth+1..2*Depth, done pulse at 2*Depth+2.
// Backpressure: none; one request per cycle, and a response is expected exactly one cycle after each request.
module mem_march_bist #(
    parameter int unsigned Depth    = 128,
    parameter logic [31:0] BaseAddr = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [31:0] pattern_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [31:0] err_addr_o,
    output logic [31:0] err_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned   IW   = $clog2(Depth) + 1;
    localparam logic [IW-1:0] LAST = IW'(Depth - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [31:0]   seed_q, seed_d;
    logic          start_ok;

    // The outputs are registered from the next state, so the request on the bus in
    // a given cycle always belongs to the state/index held during that cycle.
    logic          req_d, we_d;
    logic [31:0]   addr_d, wdata_d;

    // Read currently awaiting its response (compared one cycle after issue).
    logic          pend_q;
    logic [31:0]   pend_exp_q, pend_addr_q;
    logic          cmp_fail;
    logic [31:0]   fail_rdata;

    // Next-state, index and seed selection; the bus request is derived from the next state.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        seed_d   = seed_q;
        start_ok = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    start_ok = 1'b1;
                    seed_d   = pattern_i;
                    idx_d    = '0;
                    state_d  = S_WRITE;
                end
            end
            S_WRITE: begin
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    state_d = S_READ;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_READ: begin
                if (idx_q == LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        req_d   = (state_d == S_WRITE) || (state_d == S_READ);
        we_d    = (state_d == S_WRITE);
        addr_d  = req_d ? (BaseAddr + (32'(idx_d) << 2)) : 32'h0;
        wdata_d = we_d ? (seed_d ^ 32'(idx_d)) : 32'h0;
    end

    // A failure is a pending read with either no response or a wrong word.
    assign cmp_fail   = pend_q && (!mem_rvalid_i || (mem_rdata_i != pend_exp_q));
    assign fail_rdata = mem_rvalid_i ? mem_rdata_i : 32'h0;

    // FSM state, index and latched seed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            seed_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            seed_q  <= seed_d;
        end
    end

    // Registered memory request and status outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= 4'h0;
            mem_addr_o  <= 32'h0;
            mem_wdata_o <= 32'h0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            mem_req_o   <= req_d;
            mem_we_o    <= we_d;
            mem_be_o    <= {4{req_d}};
            mem_addr_o  <= addr_d;
            mem_wdata_o <= wdata_d;
            busy_o      <= req_d || (state_d == S_DRAIN);
            done_o      <= (state_d == S_DONE);
        end
    end

    // Remember the read on the bus this cycle so its response can be checked next cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q      <= 1'b0;
            pend_exp_q  <= 32'h0;
            pend_addr_q <= 32'h0;
        end else begin
            pend_q      <= (state_q == S_READ);
            pend_exp_q  <= seed_q ^ 32'(idx_q);
            pend_addr_q <= mem_addr_o;
        end
    end

    // Sticky error flag with first-failure capture; cleared only by an accepted start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            error_o     <= 1'b0;
            err_addr_o  <= 32'h0;
            err_rdata_o <= 32'h0;
        end else if (start_ok) begin
            error_o     <= 1'b0;
            err_addr_o  <= 32'h0;
            err_rdata_o <= 32'h0;
        end else if (cmp_fail) begin
            error_o <= 1'b1;
            if (!error_o) begin
                err_addr_o  <= pend_addr_q;
                err_rdata_o <= fail_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_march_bist.sv
// Purpose: self-checking bench for mem_march_bist against a RAM model with injectable read faults.
// Latency: checks every cycle of each run against the cycle-numbered schedule of requests and status.
// Backpressure: RAM model answers every request one cycle later; faults flip data or drop rvalid.
module tb_mem_march_bist;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h100;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] pattern;
    logic        busy, done, error;
    logic [31:0] err_addr, err_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    // RAM contents and per-word read fault injection.
    logic [31:0] ram  [DEPTH];
    logic [31:0] flip [DEPTH];
    bit          supp [DEPTH];

    mem_march_bist #(
        .Depth    (DEPTH),
        .BaseAddr (BASE)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .pattern_i    (pattern),
        .busy_o       (busy),
        .done_o       (done),
        .error_o      (error),
        .err_addr_o   (err_addr),
        .err_rdata_o  (err_rdata),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_be_o     (mem_be),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    // Single-cycle RAM: samples the request mid-cycle, answers just after the next edge.
    always begin
        logic        r_req, r_we;
        logic [31:0] r_addr, r_wdata, off;
        bit          in_rng;
        @(negedge clk);
        r_req   = mem_req;
        r_we    = mem_we;
        r_addr  = mem_addr;
        r_wdata = mem_wdata;
        @(posedge clk);
        #1;
        off    = (r_addr - BASE) >> 2;
        in_rng = (off < DEPTH) && (r_addr[1:0] == 2'b00);
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        if (r_req === 1'b1) begin
            if (r_we) begin
                if (in_rng) ram[off] = r_wdata;
                mem_rvalid = 1'b1;
            end else begin
                mem_rvalid = !(in_rng && supp[off]);
                mem_rdata  = in_rng ? (ram[off] ^ flip[off]) : 32'h0;
            end
        end
    end

    task automatic clear_faults();
        for (int j = 0; j < DEPTH; j++) begin
            flip[j] = 32'h0;
            supp[j] = 1'b0;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {23'h0, busy, done, error, mem_req, mem_we, mem_be}, 32'h0);
        chk({tag, "_eaddr"}, err_addr, 32'h0);
        chk({tag, "_erdata"}, err_rdata, 32'h0);
        chk({tag, "_addr"}, mem_addr, 32'h0);
        chk({tag, "_wdata"}, mem_wdata, 32'h0);
    endtask

    // One full run checked cycle by cycle; stray > 0 pulses start_i during that cycle.
    task automatic run_bist(input logic [31:0] pat, input int stray);
        int          first;
        int          nreq;
        int          i;
        logic [31:0] e_rdata;
        logic        e_busy, e_done, e_req, e_we, e_err;
        first   = -1;
        e_rdata = 32'h0;
        for (int j = 0; j < DEPTH; j++) begin
            if (first < 0 && (supp[j] || flip[j] != 32'h0)) begin
                first   = j;
                e_rdata = supp[j] ? 32'h0 : ((pat ^ 32'(j)) ^ flip[j]);
            end
        end
        @(negedge clk);
        start   = 1'b1;
        pattern = pat;
        @(negedge clk);
        start   = 1'b0;
        pattern = $urandom;
        nreq    = 0;
        for (int k = 1; k <= 2 * DEPTH + 3; k++) begin
            if (k > 1) begin
                @(negedge clk);
                start = 1'b0;
            end
            e_busy = (k <= 2 * DEPTH + 1);
            e_done = (k == 2 * DEPTH + 2);
            e_req  = (k <= 2 * DEPTH);
            e_we   = (k <= DEPTH);
            e_err  = (first >= 0) && (k >= DEPTH + 3 + first);
            i      = e_we ? (k - 1) : (k - DEPTH - 1);
            chk($sformatf("ctl_c%0d", k), {24'h0, busy, done, mem_req, mem_we, mem_be},
                {24'h0, e_busy, e_done, e_req, e_we, {4{e_req}}});
            if (e_req) chk($sformatf("addr_c%0d", k), mem_addr, BASE + 32'(4 * i));
            if (e_we)  chk($sformatf("wdata_c%0d", k), mem_wdata, pat ^ 32'(i));
            chk($sformatf("err_flag_c%0d", k), {31'h0, error}, {31'h0, e_err});
            if (mem_req === 1'b1) nreq++;
            if (k == stray) start = 1'b1;
        end
        chk("req_count", 32'(nreq), 32'(2 * DEPTH));
        chk("err_addr", err_addr, (first < 0) ? 32'h0 : BASE + 32'(4 * first));
        chk("err_rdata", err_rdata, e_rdata);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        pattern    = 32'h0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        clear_faults();
        for (int j = 0; j < DEPTH; j++) ram[j] = 32'h0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Clean run, then single fault, two faults, and a dropped response.
        run_bist(32'hA5A5_0000, 0);
        flip[2] = 32'h1;
        run_bist(32'hA5A5_0000, 0);
        clear_faults();
        flip[1] = 32'h0000_0100;
        flip[3] = 32'h8000_0000;
        run_bist(32'hA5A5_0000, 0);
        clear_faults();
        supp[0] = 1'b1;
        run_bist(32'hA5A5_0000, 0);
        clear_faults();

        // Starts during a run and during DONE are ignored.
        run_bist(32'h1234_5678, 3);
        run_bist(32'h1234_5678, 2 * DEPTH + 2);

        // Reset while idle with a captured failure wipes the capture registers.
        flip[0] = 32'hFFFF_0000;
        run_bist(32'hCAFE_F00D, 0);
        clear_faults();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_idle");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of the write phase.
        @(negedge clk);
        start   = 1'b1;
        pattern = 32'h5555_AAAA;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rst_hold_req%0d", c), {31'h0, mem_req}, 32'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {30'h0, busy, mem_req}, 32'h0);
        run_bist(32'h0, 0);

        // A failing run followed by a clean run: start clears the flag.
        flip[3] = 32'h0000_0010;
        run_bist(32'h0F0F_0F0F, 0);
        clear_faults();
        run_bist(32'h0F0F_0F0F, 0);

        // Randomized runs with random faults and stray starts.
        for (int r = 0; r < 16; r++) begin
            clear_faults();
            if ($urandom_range(0, 1) == 1) begin
                int j;
                j = int'($urandom_range(0, DEPTH - 1));
                if ($urandom_range(0, 2) == 0) supp[j] = 1'b1;
                else flip[j] = $urandom | 32'h1;
                if ($urandom_range(0, 1) == 1) begin
                    j = int'($urandom_range(0, DEPTH - 1));
                    flip[j] = flip[j] | (32'h1 << $urandom_range(0, 31));
                end
            end
            run_bist($urandom, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 2 * DEPTH + 2)) : 0);
        end
        clear_faults();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
